stbc_codeword_encoder: RTL
==========================

// Module: stbc_codeword_encoder
// PURPOSE
//  Transmit-side codeword mapper for the 4-antenna x 2-slot codebook S_q (q = 0..15) used by the Hq = H*S_q detector.
//  Accepts 4-bit codeword indices on a ready/valid stream and buffers them in a 2-deep FIFO.
//  Emits each codeword as 8 serial complex Q-format samples (slot j outer, antenna k inner) toward the DAC/tx path.
// PARAMETERS
//  Q   8   fractional bits; unit magnitude 0.5 = 2^(Q-1). Constraint: Q <= N-1.
//  N   16  sample width (signed, per rail)
// PORTS
//  clk          in   1   clock; all logic on rising edge
//  rst          in   1   synchronous, active-high reset
//  q_in_valid   in   1   codeword index valid
//  q_in_ready   out  1   FIFO not full (= count<2)
//  q_in         in   4   codeword index q
//  s_out_valid  out  1   sample valid
//  s_out_ready  in   1   downstream accepts sample
//  s_out_r      out  N   sample real, signed
//  s_out_i      out  N   sample imag, signed
//  s_out_k      out  2   antenna index of current sample
//  s_out_j      out  1   time-slot index of current sample
//  s_out_last   out  1   high on 8th sample (j=1,k=3) of a codeword
//  busy         out  1   FIFO non-empty or codeword in flight
// BEHAVIOUR
//  Codebook: H=2^(Q-1); a = {+1,-1,+j,-j}[q[3:2]]; b = {+1,+j,-1,-j}[q[1:0]]
//   S[0][j]=(+1,+1)  S[1][j]=(-1,+1)  S[2][j]=(a,b)  S[3][j]=(-conj(b),a); each entry scaled by H.
//  Reset: s_out_valid=0, s_out_r/i=0, s_out_k=0, s_out_j=0, s_out_last=0, busy=0; FIFO emptied (q_in_ready=1); state=IDLE.
//  FIFO: push on q_in_valid&q_in_ready. Pop only when loading a codeword.
//   Push and pop in the same cycle are legal at count=1; count unchanged.
//  FSM IDLE: FIFO non-empty -> pop, latch q, k=j=0, go EMIT. Output regs load sample (0,0); s_out_valid=1 next cycle.
//  FSM EMIT: on s_out_valid&s_out_ready advance k (then j).
//   - last sample, FIFO non-empty: pop and present next codeword's (0,0) in the next cycle (no bubble).
//   - last sample, FIFO empty: s_out_valid=0 and return to IDLE.
//  Latency: q accepted at edge t into empty block -> first sample valid after edge t+2. Throughput 1 sample/clk, 8 clk/codeword.
//  Stall: while s_out_valid & !s_out_ready, all s_out_* held stable. Valid never drops without a handshake.
//  Widths: outputs are exactly +-H or 0 (no arithmetic overflow possible with Q<=N-1).
//  Reset mid-codeword: sample stream aborted at once, buffered indices discarded, outputs at reset values next cycle.
// CONFIGURATION
//  STBC_ENC_GAIN_EN defined:
//   - adds port gain_in (in, N, signed Q-format), sampled when a codeword is loaded and held for its 8 samples.
//   - unit entry = gain_in>>>1 (arithmetic shift, truncation toward -inf); -1 entries = -(gain_in>>>1).
//   - gain_in = -2^(N-1) is saturated to -(2^(N-1))>>>1 magnitude before negation.
//  STBC_ENC_GAIN_EN undefined: no gain_in port; unit entry fixed at +-2^(Q-1) (128 for Q=8).
// TESTING
//  1 rst held 2 clk -> s_out_valid=0, s_out_r/i=0, q_in_ready=1, busy=0.
//  2 push q=0 -> (128,0),(-128,0),(128,0),(-128,0),(128,0),(128,0),(128,0),(128,0); s_out_last on 8th only; first valid at t+2.
//  3 push q=9 -> (128,0),(-128,0),(0,128),(0,128),(128,0),(128,0),(0,128),(0,128).
//  4 push q=5 then q=15, s_out_ready=1 -> 16 consecutive valid samples, no bubble; last at 8 and 16.
//     q=15 k2/k3 = (0,-128) in both slots.
//  5 deassert s_out_ready for 3 clk at sample 3; push 3 indices -> sample held stable; q_in_ready=0 while 2 buffered; no index lost.
//  6 rst asserted at sample 5 with 1 index buffered -> next cycle s_out_valid=0, busy=0; the buffered index is never emitted.

Source files
------------

// File: rtl/stbc_codeword_encoder.sv
`default_nettype none
// ============================================================================
// Module   : stbc_codeword_encoder
// Purpose  : Transmit-side mapper for the 4-antenna x 2-slot codebook S_q
//            (q = 0..15). Codeword indices arrive on a ready/valid stream and
//            are buffered in a 2-deep FIFO. Each codeword is emitted as 8
//            serial complex samples, slot j outer and antenna k inner.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            q_in_valid/ready  - codeword index handshake (ready = FIFO count < 2)
//            q_in[3:0]         - codeword index q
//            s_out_valid/ready - sample handshake
//            s_out_r/s_out_i   - signed sample, real and imaginary rails (N bits)
//            s_out_k, s_out_j  - antenna and time-slot index of current sample
//            s_out_last        - marks the 8th sample (j=1, k=3) of a codeword
//            busy              - FIFO non-empty or a codeword in flight
//            gain_in           - signed Q-format gain (STBC_ENC_GAIN_EN only)
// Option   : STBC_ENC_GAIN_EN  - adds gain_in; unit entry = gain_in >>> 1.
//                                Undefined: unit entry fixed at 2^(Q-1).
// Revision : 1.0 - initial release
// ============================================================================
module stbc_codeword_encoder #(
    parameter int Q = 8,
    parameter int N = 16
) (
    input  logic                clk,
    input  logic                rst,
`ifdef STBC_ENC_GAIN_EN
    input  logic signed [N-1:0] gain_in,
`endif
    input  logic                q_in_valid,
    output logic                q_in_ready,
    input  logic [3:0]          q_in,
    output logic                s_out_valid,
    input  logic                s_out_ready,
    output logic signed [N-1:0] s_out_r,
    output logic signed [N-1:0] s_out_i,
    output logic [1:0]          s_out_k,
    output logic                s_out_j,
    output logic                s_out_last,
    output logic                busy
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_EMIT = 2'd2;

    // Codebook entries are always one of four unit phases.
    localparam logic [1:0] c_E_P1 = 2'd0;  // +1
    localparam logic [1:0] c_E_M1 = 2'd1;  // -1
    localparam logic [1:0] c_E_PJ = 2'd2;  // +j
    localparam logic [1:0] c_E_MJ = 2'd3;  // -j

    logic [3:0]          r_mem [2];
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [1:0]          r_count;
    logic [1:0]          r_state;
    logic [3:0]          r_q;

    logic                w_push;
    logic                w_pop;
    logic                w_fifo_nonempty;
    logic                w_out_fire;
    logic [3:0]          w_head;
    logic [1:0]          w_next_k;
    logic                w_next_j;
    logic                w_next_last;
    logic signed [N-1:0] w_unit_cur;
    logic signed [N-1:0] w_unit_new;
    logic [2*N-1:0]      w_adv_sample;
    logic [2*N-1:0]      w_first_cur;
    logic [2*N-1:0]      w_first_new;

`ifdef STBC_ENC_GAIN_EN
    logic signed [N-1:0] r_gain;

    // gain_in = -2^(N-1) shifts to -2^(N-2), whose negation still fits in
    // N bits, so the most-negative input needs no separate clamp.
    assign w_unit_cur = r_gain >>> 1;
    assign w_unit_new = gain_in >>> 1;

    // Gain is captured together with the codeword it applies to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gain <= '0;
        end else if (w_pop) begin
            r_gain <= gain_in;
        end
    end
`else
    localparam int                c_UNIT_INT = 1 << (Q - 1);
    localparam logic signed [N-1:0] c_UNIT   = N'(c_UNIT_INT);

    assign w_unit_cur = c_UNIT;
    assign w_unit_new = c_UNIT;
`endif

    // Returns {real, imag} of entry S[k][j] for codeword q, scaled by unit.
    function automatic logic [2*N-1:0] f_sample(
        input logic [3:0]          q,
        input logic [1:0]          k,
        input logic                j,
        input logic signed [N-1:0] unit
    );
        logic [1:0]          a_code;
        logic [1:0]          b_code;
        logic [1:0]          nb_code;
        logic [1:0]          code;
        logic signed [N-1:0] neg_unit;
        logic signed [N-1:0] re;
        logic signed [N-1:0] im;
        // a table {+1,-1,+j,-j} matches the entry encoding directly.
        a_code = q[3:2];
        // b = {+1,+j,-1,-j}; nb_code is -conj(b).
        case (q[1:0])
            2'd0:    begin b_code = c_E_P1; nb_code = c_E_M1; end
            2'd1:    begin b_code = c_E_PJ; nb_code = c_E_PJ; end
            2'd2:    begin b_code = c_E_M1; nb_code = c_E_P1; end
            default: begin b_code = c_E_MJ; nb_code = c_E_MJ; end
        endcase
        case (k)
            2'd0:    code = c_E_P1;
            2'd1:    code = j ? c_E_P1 : c_E_M1;
            2'd2:    code = j ? b_code : a_code;
            default: code = j ? a_code : nb_code;
        endcase
        neg_unit = -unit;
        re = '0;
        im = '0;
        case (code)
            c_E_P1:  re = unit;
            c_E_M1:  re = neg_unit;
            c_E_PJ:  im = unit;
            default: im = neg_unit;
        endcase
        return {re, im};
    endfunction

    assign q_in_ready      = (r_count < 2'd2);
    assign w_fifo_nonempty = (r_count != 2'd0);
    assign w_push          = q_in_valid & q_in_ready;
    assign w_out_fire      = s_out_valid & s_out_ready;
    assign w_head          = r_mem[r_rd_ptr];
    // Pop from IDLE, or on the final handshake of a codeword so the next one
    // follows without a bubble.
    assign w_pop = w_fifo_nonempty &
                   ((r_state == c_ST_IDLE) |
                    ((r_state == c_ST_EMIT) & w_out_fire & s_out_last));
    assign busy  = w_fifo_nonempty | (r_state != c_ST_IDLE);

    // The output k/j registers double as the sample position counters.
    assign w_next_k    = s_out_k + 2'd1;
    assign w_next_j    = s_out_j | (s_out_k == 2'd3);
    assign w_next_last = (w_next_k == 2'd3) & w_next_j;

    assign w_adv_sample = f_sample(r_q, w_next_k, w_next_j, w_unit_cur);
    assign w_first_cur  = f_sample(r_q, 2'd0, 1'b0, w_unit_cur);
    assign w_first_new  = f_sample(w_head, 2'd0, 1'b0, w_unit_new);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= q_in;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_q         <= 4'd0;
            s_out_valid <= 1'b0;
            s_out_r     <= '0;
            s_out_i     <= '0;
            s_out_k     <= 2'd0;
            s_out_j     <= 1'b0;
            s_out_last  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        r_q     <= w_head;
                        r_state <= c_ST_LOAD;
                    end
                end
                c_ST_LOAD: begin
                    {s_out_r, s_out_i} <= w_first_cur;
                    s_out_valid        <= 1'b1;
                    s_out_k            <= 2'd0;
                    s_out_j            <= 1'b0;
                    s_out_last         <= 1'b0;
                    r_state            <= c_ST_EMIT;
                end
                c_ST_EMIT: begin
                    if (w_out_fire) begin
                        if (s_out_last) begin
                            s_out_k    <= 2'd0;
                            s_out_j    <= 1'b0;
                            s_out_last <= 1'b0;
                            if (w_fifo_nonempty) begin
                                r_q                <= w_head;
                                {s_out_r, s_out_i} <= w_first_new;
                            end else begin
                                s_out_valid        <= 1'b0;
                                {s_out_r, s_out_i} <= '0;
                                r_state            <= c_ST_IDLE;
                            end
                        end else begin
                            {s_out_r, s_out_i} <= w_adv_sample;
                            s_out_k            <= w_next_k;
                            s_out_j            <= w_next_j;
                            s_out_last         <= w_next_last;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
